mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares one single-outstanding memory port between N_REQ algorithmic engines, e.g. several matmul instances, that use the mem_req/mem_write/mem_addr/mem_wdata request style. Round-robin selection, one transaction in flight, and read data routed back to the issuing requester. Sits between the engine array and the memory controller. Includes a read timeout so a lost mem_rdata_vld cannot hang the engines.

Parameters:
N_REQ, 4, number of requesters (2..16)
MEM_AW, 16, address width
MEM_DW, 32, data width
IDX_W, $clog2(N_REQ), owner index width
TIMEOUT, 255, maximum RWAIT cycles before forced completion (1..65535)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
req_valid  in  N_REQ  per-requester request pending
req_write  in  N_REQ  1=write, 0=read
req_addr  in  N_REQ*MEM_AW  packed addresses; requester k at [k*MEM_AW +: MEM_AW]
req_wdata  in  N_REQ*MEM_DW  packed write data
req_ack  out  N_REQ  one-cycle pulse: request accepted/issued
rsp_vld  out  N_REQ  one-cycle pulse: read data returned to that requester
rsp_data  out  MEM_DW  read data, broadcast; qualified by rsp_vld
mem_req  out  1  memory request strobe
mem_write  out  1  memory write enable
mem_addr  out  MEM_AW  memory address
mem_wdata  out  MEM_DW  memory write data
mem_rdata_vld  in  1  read data valid
mem_rdata  in  MEM_DW  read data
busy  out  1  high when state != IDLE
owner  out  IDX_W  index of current/last granted requester
err  out  1  sticky: timeout or unsolicited mem_rdata_vld

Behaviour:
- Reset: all outputs 0; state=IDLE; rr_ptr=0; timeout counter=0.
- All outputs are registered.
- States: IDLE, ISSUE, RWAIT, RESP.
- IDLE:
  - If any req_valid, winner w = first set bit searching from rr_ptr upward, wrapping modulo N_REQ.
  - On that edge: latch mem_addr/mem_wdata/mem_write from w; mem_req=1; req_ack[w]=1; owner=w; rr_ptr=(w+1) mod N_REQ; go to ISSUE.
- ISSUE (exactly 1 cycle, mem_req and req_ack high):
  - Write: next state IDLE; mem_req, req_ack drop. Write throughput is 1 per 2 cycles.
  - Read: if mem_rdata_vld is already high this cycle, capture rsp_data and go to RESP. Otherwise go to RWAIT with counter=1.
- RWAIT: mem_req=0, addr held.
  - On mem_rdata_vld: rsp_data<=mem_rdata, go to RESP.
  - Else if counter==TIMEOUT: rsp_data<=all ones, err<=1, go to RESP.
  - Else counter+1.
- RESP (1 cycle): rsp_vld[owner]=1, then IDLE. A new arbitration starts in the following IDLE cycle.
- Requester contract: hold req_valid and fields stable until req_ack. The next request may be raised on the cycle after ack.
  - Readers must not issue another request before their rsp_vld.
  - A request is not issued again while its requester's req_valid stays high only if the requester drops it after ack. Arbitration samples only in IDLE.
- Dropping req_valid before ack is legal; the request is never issued.
- mem_rdata_vld in IDLE, ISSUE(write) or RESP is ignored for data and sets err.
- mem_rdata_vld in the same cycle as the timeout comparison: the data wins, no err.
- rr_ptr advances only on grant. A requester waits at most N_REQ-1 grants.
- Reset mid-transaction: immediate return to IDLE, outputs 0. No rsp_vld is emitted for the aborted read.

Decomposition:
- Package mem_arb_pkg: state enum (IDLE/ISSUE/RWAIT/RESP), TIMEOUT counter width constant, ALL_ONES constant.
- Sub-module mem_rr_pick: combinational round-robin picker (req vector, rr_ptr -> any, winner index). It is reused by future arbiters.

Test Plan:
- Write from requester 2 only, addr 0x0011, data 0xFFFFFFEE -> req_ack[2] and mem_req high for exactly 1 cycle with those values; busy 1 cycle; no rsp_vld.
- Requesters 0,1,3 all hold write requests from reset -> grant order 0,1,3,0...; each ack 2 cycles apart; no requester starved.
- Read by requester 1, memory returns 0xCAFE0001 three cycles after mem_req -> rsp_vld[1] pulses once, 1 cycle after mem_rdata_vld, rsp_data=0xCAFE0001.
- Read with mem_rdata_vld never asserted, TIMEOUT=8 -> rsp_vld pulses 9 cycles after ISSUE, rsp_data=0xFFFFFFFF, err=1 and stays 1.
- Assert rst while in RWAIT, then return mem_rdata_vld -> all outputs 0 immediately; no rsp_vld; err set by the unsolicited vld.
- Zero-latency read (mem_rdata_vld during ISSUE, data 0x5) -> RESP entered directly; rsp_data=0x5; no err.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared constants for the single-outstanding memory port arbiter.
// FSM encodings, timeout counter sizing and the read-timeout fill pattern.
package mem_arb_pkg;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ST_IDLE  = 2'd0;
    localparam arb_state_t ST_ISSUE = 2'd1;
    localparam arb_state_t ST_RWAIT = 2'd2;
    localparam arb_state_t ST_RESP  = 2'd3;

    // Wide enough for TIMEOUT up to 65535.
    localparam int CNT_W = 16;

    // Sliced down to MEM_DW by the user; returned as read data on a timeout.
    localparam logic [255:0] ALL_ONES = '1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Engine-array and memory-controller side signals of mem_port_arbiter.
// slave is the arbiter's view; master is the engines-plus-memory view.
interface mem_port_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int MEM_AW = 16,
    parameter int MEM_DW = 32,
    parameter int IDX_W  = $clog2(N_REQ)
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_write;
    logic [N_REQ*MEM_AW-1:0] req_addr;
    logic [N_REQ*MEM_DW-1:0] req_wdata;
    logic [N_REQ-1:0]        req_ack;
    logic [N_REQ-1:0]        rsp_vld;
    logic [MEM_DW-1:0]       rsp_data;
    logic                    mem_req;
    logic                    mem_write;
    logic [MEM_AW-1:0]       mem_addr;
    logic [MEM_DW-1:0]       mem_wdata;
    logic                    mem_rdata_vld;
    logic [MEM_DW-1:0]       mem_rdata;
    logic                    busy;
    logic [IDX_W-1:0]        owner;
    logic                    err;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, mem_rdata_vld, mem_rdata,
        output req_ack, rsp_vld, rsp_data, mem_req, mem_write, mem_addr, mem_wdata,
               busy, owner, err
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, mem_rdata_vld, mem_rdata,
        input  req_ack, rsp_vld, rsp_data, mem_req, mem_write, mem_addr, mem_wdata,
               busy, owner, err
    );
endinterface

// File: rtl/mem_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module mem_rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             any,
    output logic [IDX_W-1:0] idx
);
    logic [IDX_W-1:0] cand [N_REQ];

    // cand[k] is the requester examined k steps after ptr.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
        assign cand[gi] = IDX_W'((int'(ptr) + gi) % N_REQ);
    end

    always_comb begin
        any = |req;
        idx = ptr;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[cand[i]]) begin
                idx = cand[i];
            end
        end
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin share of one single-outstanding memory port among N_REQ engines,
// with read data routed back to the issuer and a bounded wait for read data.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int MEM_AW  = 16,
    parameter int MEM_DW  = 32,
    parameter int IDX_W   = $clog2(N_REQ),
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
);
    arb_state_t        state_reg;
    logic [IDX_W-1:0]  rr_ptr_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [IDX_W-1:0]  owner_reg;
    logic [N_REQ-1:0]  ack_reg;
    logic [N_REQ-1:0]  rsp_vld_reg;
    logic [MEM_DW-1:0] rsp_data_reg;
    logic              mem_req_reg;
    logic              mem_write_reg;
    logic [MEM_AW-1:0] mem_addr_reg;
    logic [MEM_DW-1:0] mem_wdata_reg;
    logic              err_reg;

    logic [MEM_AW-1:0] addr_arr  [N_REQ];
    logic [MEM_DW-1:0] wdata_arr [N_REQ];
    logic              pick_any;
    logic [IDX_W-1:0]  pick_idx;
    logic [IDX_W-1:0]  rr_ptr_next;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
        assign addr_arr[gi]  = bus.req_addr[gi*MEM_AW +: MEM_AW];
        assign wdata_arr[gi] = bus.req_wdata[gi*MEM_DW +: MEM_DW];
    end

    mem_rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
        .req (bus.req_valid),
        .ptr (rr_ptr_reg),
        .any (pick_any),
        .idx (pick_idx)
    );

    assign rr_ptr_next = (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            rr_ptr_reg    <= '0;
            cnt_reg       <= '0;
            owner_reg     <= '0;
            ack_reg       <= '0;
            rsp_vld_reg   <= '0;
            rsp_data_reg  <= '0;
            mem_req_reg   <= 1'b0;
            mem_write_reg <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            err_reg       <= 1'b0;
        end else begin
            // Handshake strobes are single-cycle pulses unless re-armed below.
            ack_reg     <= '0;
            rsp_vld_reg <= '0;
            mem_req_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (bus.mem_rdata_vld) err_reg <= 1'b1;
                    if (pick_any) begin
                        mem_addr_reg      <= addr_arr[pick_idx];
                        mem_wdata_reg     <= wdata_arr[pick_idx];
                        mem_write_reg     <= bus.req_write[pick_idx];
                        mem_req_reg       <= 1'b1;
                        ack_reg[pick_idx] <= 1'b1;
                        owner_reg         <= pick_idx;
                        rr_ptr_reg        <= rr_ptr_next;
                        state_reg         <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (mem_write_reg) begin
                        if (bus.mem_rdata_vld) err_reg <= 1'b1;
                        state_reg <= ST_IDLE;
                    end else if (bus.mem_rdata_vld) begin
                        rsp_data_reg           <= bus.mem_rdata;
                        rsp_vld_reg[owner_reg] <= 1'b1;
                        state_reg              <= ST_RESP;
                    end else begin
                        cnt_reg   <= CNT_W'(1);
                        state_reg <= ST_RWAIT;
                    end
                end
                ST_RWAIT: begin
                    // Returned data takes priority over an expiring timeout.
                    if (bus.mem_rdata_vld) begin
                        rsp_data_reg           <= bus.mem_rdata;
                        rsp_vld_reg[owner_reg] <= 1'b1;
                        cnt_reg                <= '0;
                        state_reg              <= ST_RESP;
                    end else if (cnt_reg == CNT_W'(TIMEOUT)) begin
                        rsp_data_reg           <= ALL_ONES[MEM_DW-1:0];
                        rsp_vld_reg[owner_reg] <= 1'b1;
                        err_reg                <= 1'b1;
                        cnt_reg                <= '0;
                        state_reg              <= ST_RESP;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (bus.mem_rdata_vld) err_reg <= 1'b1;
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ack   = ack_reg;
    assign bus.rsp_vld   = rsp_vld_reg;
    assign bus.rsp_data  = rsp_data_reg;
    assign bus.mem_req   = mem_req_reg;
    assign bus.mem_write = mem_write_reg;
    assign bus.mem_addr  = mem_addr_reg;
    assign bus.mem_wdata = mem_wdata_reg;
    assign bus.busy      = (state_reg != ST_IDLE);
    assign bus.owner     = owner_reg;
    assign bus.err       = err_reg;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed checks of mem_port_arbiter: writes, round-robin order, reads,
// timeout, reset during a read and zero-latency read.
module tb_mem_port_arbiter;
    localparam int N_REQ  = 4;
    localparam int MEM_AW = 16;
    localparam int MEM_DW = 32;
    localparam int IDX_W  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.N_REQ(N_REQ), .MEM_AW(MEM_AW), .MEM_DW(MEM_DW), .IDX_W(IDX_W)) bus ();

    mem_port_arbiter #(
        .N_REQ(N_REQ), .MEM_AW(MEM_AW), .MEM_DW(MEM_DW), .IDX_W(IDX_W), .TIMEOUT(8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int k, input logic wr, input logic [15:0] a, input logic [31:0] d);
        bus.req_write[k]           = wr;
        bus.req_addr[k*MEM_AW +: MEM_AW] = a;
        bus.req_wdata[k*MEM_DW +: MEM_DW] = d;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int exp_w;
        bus.req_valid     = '0;
        bus.req_write     = '0;
        bus.req_addr      = '0;
        bus.req_wdata     = '0;
        bus.mem_rdata_vld = 1'b0;
        bus.mem_rdata     = '0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_ack",     64'(bus.req_ack),   64'h0);
        chk("rst_rsp_vld", 64'(bus.rsp_vld),   64'h0);
        chk("rst_rsp_dat", 64'(bus.rsp_data),  64'h0);
        chk("rst_mem_req", 64'(bus.mem_req),   64'h0);
        chk("rst_addr",    64'(bus.mem_addr),  64'h0);
        chk("rst_busy",    64'(bus.busy),      64'h0);
        chk("rst_owner",   64'(bus.owner),     64'h0);
        chk("rst_err",     64'(bus.err),       64'h0);
        rst = 1'b0;

        // Single write from requester 2
        @(negedge clk);
        set_req(2, 1'b1, 16'h0011, 32'hFFFF_FFEE);
        bus.req_valid = 4'b0100;
        @(negedge clk);
        chk("w2_ack",   64'(bus.req_ack),   64'h4);
        chk("w2_req",   64'(bus.mem_req),   64'h1);
        chk("w2_wr",    64'(bus.mem_write), 64'h1);
        chk("w2_addr",  64'(bus.mem_addr),  64'h0011);
        chk("w2_wdata", 64'(bus.mem_wdata), 64'hFFFF_FFEE);
        chk("w2_owner", 64'(bus.owner),     64'h2);
        chk("w2_busy",  64'(bus.busy),      64'h1);
        bus.req_valid = '0;
        @(negedge clk);
        chk("w2_ack_off",  64'(bus.req_ack), 64'h0);
        chk("w2_req_off",  64'(bus.mem_req), 64'h0);
        chk("w2_busy_off", 64'(bus.busy),    64'h0);
        chk("w2_no_rsp",   64'(bus.rsp_vld), 64'h0);
        $display("txn write req=2 addr=%h data=%h", bus.mem_addr, bus.mem_wdata);

        // Round robin among 0,1,3 holding writes
        pulse_reset();
        for (int k = 0; k < N_REQ; k++) set_req(k, 1'b1, 16'(16'h0100 + k), 32'(32'hA000 + k));
        bus.req_valid = 4'b1011;
        for (int g = 0; g < 6; g++) begin
            exp_w = (g % 3 == 2) ? 3 : (g % 3);
            @(negedge clk);
            chk("rr_ack",   64'(bus.req_ack),  64'(1 << exp_w));
            chk("rr_addr",  64'(bus.mem_addr), 64'(16'h0100 + exp_w));
            chk("rr_owner", 64'(bus.owner),    64'(exp_w));
            $display("txn rr grant=%0d owner=%0d", g, bus.owner);
            if (g == 5) bus.req_valid = '0;
            @(negedge clk);
            chk("rr_gap", 64'(bus.req_ack), 64'h0);
        end
        @(negedge clk);
        chk("rr_quiet", 64'(bus.mem_req), 64'h0);

        // Read by requester 1, data 3 cycles after mem_req
        set_req(1, 1'b0, 16'h0042, 32'h0);
        bus.req_valid = 4'b0010;
        @(negedge clk);
        chk("rd1_ack", 64'(bus.req_ack),   64'h2);
        chk("rd1_wr",  64'(bus.mem_write), 64'h0);
        bus.req_valid = '0;
        @(negedge clk);
        chk("rd1_wait_req",  64'(bus.mem_req),  64'h0);
        chk("rd1_wait_addr", 64'(bus.mem_addr), 64'h0042);
        chk("rd1_wait_busy", 64'(bus.busy),     64'h1);
        @(negedge clk);
        chk("rd1_wait_rsp", 64'(bus.rsp_vld), 64'h0);
        @(negedge clk);
        bus.mem_rdata_vld = 1'b1;
        bus.mem_rdata     = 32'hCAFE_0001;
        @(negedge clk);
        bus.mem_rdata_vld = 1'b0;
        chk("rd1_rsp_vld", 64'(bus.rsp_vld),  64'h2);
        chk("rd1_rsp_dat", 64'(bus.rsp_data), 64'hCAFE_0001);
        chk("rd1_err",     64'(bus.err),      64'h0);
        $display("txn read req=1 data=%h", bus.rsp_data);
        @(negedge clk);
        chk("rd1_rsp_once", 64'(bus.rsp_vld), 64'h0);
        chk("rd1_idle",     64'(bus.busy),    64'h0);

        // Read by requester 3 with no returned data: timeout after 8 wait cycles
        set_req(3, 1'b0, 16'h0077, 32'h0);
        bus.req_valid = 4'b1000;
        @(negedge clk);
        chk("to_ack", 64'(bus.req_ack), 64'h8);
        bus.req_valid = '0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            chk("to_wait_rsp", 64'(bus.rsp_vld), 64'h0);
            chk("to_wait_err", 64'(bus.err),     64'h0);
        end
        @(negedge clk);
        chk("to_rsp_vld", 64'(bus.rsp_vld),  64'h8);
        chk("to_rsp_dat", 64'(bus.rsp_data), 64'hFFFF_FFFF);
        chk("to_err",     64'(bus.err),      64'h1);
        $display("txn timeout req=3 data=%h err=%0d", bus.rsp_data, bus.err);
        @(negedge clk);
        chk("to_rsp_once",  64'(bus.rsp_vld), 64'h0);
        chk("to_err_stick", 64'(bus.err),     64'h1);

        // Reset during RWAIT, then an unsolicited mem_rdata_vld
        pulse_reset();
        chk("rs_err_clr", 64'(bus.err), 64'h0);
        set_req(2, 1'b0, 16'h0033, 32'h0);
        bus.req_valid = 4'b0100;
        @(negedge clk);
        chk("rs_ack", 64'(bus.req_ack), 64'h4);
        bus.req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rs_busy",  64'(bus.busy),     64'h0);
        chk("rs_owner", 64'(bus.owner),    64'h0);
        chk("rs_addr",  64'(bus.mem_addr), 64'h0);
        chk("rs_rsp",   64'(bus.rsp_vld),  64'h0);
        @(negedge clk);
        rst = 1'b0;
        bus.mem_rdata_vld = 1'b1;
        bus.mem_rdata     = 32'h0000_1234;
        @(negedge clk);
        bus.mem_rdata_vld = 1'b0;
        chk("rs_no_rsp",  64'(bus.rsp_vld),  64'h0);
        chk("rs_dat",     64'(bus.rsp_data), 64'h0);
        chk("rs_err_set", 64'(bus.err),      64'h1);
        $display("txn reset-abort err=%0d", bus.err);
        @(negedge clk);
        chk("rs_no_rsp2", 64'(bus.rsp_vld), 64'h0);

        // Zero-latency read by requester 0
        pulse_reset();
        set_req(0, 1'b0, 16'h0005, 32'h0);
        bus.req_valid = 4'b0001;
        @(negedge clk);
        chk("zl_ack", 64'(bus.req_ack), 64'h1);
        bus.req_valid     = '0;
        bus.mem_rdata_vld = 1'b1;
        bus.mem_rdata     = 32'h0000_0005;
        @(negedge clk);
        bus.mem_rdata_vld = 1'b0;
        chk("zl_rsp_vld", 64'(bus.rsp_vld),  64'h1);
        chk("zl_rsp_dat", 64'(bus.rsp_data), 64'h5);
        chk("zl_err",     64'(bus.err),      64'h0);
        $display("txn zero-latency req=0 data=%h", bus.rsp_data);
        @(negedge clk);
        chk("zl_rsp_once", 64'(bus.rsp_vld), 64'h0);
        chk("zl_idle",     64'(bus.busy),    64'h0);
        chk("zl_err2",     64'(bus.err),     64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
